// File: rtl/aclock_display_if.sv
`timescale 1ns/1ps
// aclock_display_if
//   Bundles the link between the alarm clock core and the display back-end.
//   Signals:
//     H_out1 [1:0], H_out0/M_out1/M_out0/S_out1/S_out0 [3:0]  BCD time digits
//     Alarm                                                  alarm active, level
//     seg [6:0] {g,f,e,d,c,b,a}, dp, an [5:0] one-hot         display drive
//     frame_start                                            1-clk pulse on entering digit 0
//   Transfer rules: there is no valid/ready pair and no backpressure. The digit
//   bus and Alarm are levels that the display samples only on the clock where
//   its scan wraps from the leftmost digit back to digit 0; frame_start is the
//   display's "new frame presented" strobe and marks the first clock of that
//   frame on seg/dp/an.
//   master: the clock core side (drives digits, observes display).
//   slave : the display back-end.
interface aclock_display_if;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic [3:0] S_out1;
  logic [3:0] S_out0;
  logic       Alarm;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_start;

  modport master (
    output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/aclock_display.sv
`timescale 1ns/1ps
// aclock_display
//   Time-multiplexed driver for a 6-digit common-cathode 7-segment display.
//   Each digit stays selected for SCAN_DIV clocks; the six digits and Alarm are
//   snapshotted once per frame so a frame never mixes old and new time. While
//   the snapshotted alarm is set, the display blanks on/off every BLINK_FRAMES
//   frames. When LZ_BLANK is set a leading zero in the hour tens is hidden.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous reset, active low
//     bus    aclock_display_if.slave (digits and Alarm in; seg/dp/an/frame_start out)
module aclock_display #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8,
  parameter bit LZ_BLANK     = 1'b1
) (
  input logic             clk,
  input logic             reset,
  aclock_display_if.slave bus
);

  localparam logic [7:0] SCAN_LAST  = 8'(SCAN_DIV - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] scan_cnt_q, scan_cnt_d;
  logic [2:0] dig_idx_q, dig_idx_d;
  logic [1:0] snap_h1_q, snap_h1_d;
  logic [3:0] snap_h0_q, snap_h0_d;
  logic [3:0] snap_m1_q, snap_m1_d;
  logic [3:0] snap_m0_q, snap_m0_d;
  logic [3:0] snap_s1_q, snap_s1_d;
  logic [3:0] snap_s0_q, snap_s0_d;
  logic       snap_alarm_q, snap_alarm_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [5:0] an_q, an_d;
  logic       fs_q, fs_d;

  logic       scan_last;
  logic       frame_wrap;
  logic [3:0] digit;
  logic       show;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // dash flags a non-BCD digit
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q   <= '0;
      dig_idx_q    <= '0;
      snap_h1_q    <= '0;
      snap_h0_q    <= '0;
      snap_m1_q    <= '0;
      snap_m0_q    <= '0;
      snap_s1_q    <= '0;
      snap_s0_q    <= '0;
      snap_alarm_q <= 1'b0;
      frame_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= '0;
      fs_q         <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      dig_idx_q    <= dig_idx_d;
      snap_h1_q    <= snap_h1_d;
      snap_h0_q    <= snap_h0_d;
      snap_m1_q    <= snap_m1_d;
      snap_m0_q    <= snap_m0_d;
      snap_s1_q    <= snap_s1_d;
      snap_s0_q    <= snap_s0_d;
      snap_alarm_q <= snap_alarm_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_on_q   <= blink_on_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  // Next-state: scan counters, frame snapshot, blink phase
  always_comb begin
    scan_last  = (scan_cnt_q == SCAN_LAST);
    frame_wrap = scan_last && (dig_idx_q == 3'd5);
    scan_cnt_d = scan_last ? 8'd0 : scan_cnt_q + 8'd1;

    dig_idx_d = dig_idx_q;
    if (dig_idx_q > 3'd5) begin
      dig_idx_d = 3'd0;  // recover from an unreachable index
    end else if (scan_last) begin
      dig_idx_d = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
    end

    snap_h1_d    = snap_h1_q;
    snap_h0_d    = snap_h0_q;
    snap_m1_d    = snap_m1_q;
    snap_m0_d    = snap_m0_q;
    snap_s1_d    = snap_s1_q;
    snap_s0_d    = snap_s0_q;
    snap_alarm_d = snap_alarm_q;
    if (frame_wrap) begin
      snap_h1_d    = bus.H_out1;
      snap_h0_d    = bus.H_out0;
      snap_m1_d    = bus.M_out1;
      snap_m0_d    = bus.M_out0;
      snap_s1_d    = bus.S_out1;
      snap_s0_d    = bus.S_out0;
      snap_alarm_d = bus.Alarm;
    end

    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (!snap_alarm_q) begin
      frame_cnt_d = '0;
      blink_on_d  = 1'b1;
    end
    if (frame_wrap) begin
      // A frame whose alarm sample is low, or the first frame of an alarm,
      // starts a fresh on-phase; only consecutive alarm frames advance.
      if (!bus.Alarm || !snap_alarm_q) begin
        frame_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Output decode from the current scan position; registered on the next
  // edge, so the display lags dig_idx by one clock.
  always_comb begin
    case (dig_idx_q)
      3'd0:    digit = snap_s0_q;
      3'd1:    digit = snap_s1_q;
      3'd2:    digit = snap_m0_q;
      3'd3:    digit = snap_m1_q;
      3'd4:    digit = snap_h0_q;
      3'd5:    digit = {2'b00, snap_h1_q};
      default: digit = 4'd0;
    endcase
    show = (dig_idx_q <= 3'd5) && blink_on_q &&
           !(LZ_BLANK && (dig_idx_q == 3'd5) && (snap_h1_q == 2'd0));
    an_d  = show ? (6'b000001 << dig_idx_q) : 6'd0;
    seg_d = show ? seg_decode(digit) : 7'd0;
    dp_d  = show && ((dig_idx_q == 3'd2) || (dig_idx_q == 3'd4));
    // First clock of slot 0; pulses regardless of blanking.
    fs_d  = (dig_idx_q == 3'd0) && (scan_cnt_q == 8'd0);
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_aclock_display.sv
`timescale 1ns/1ps
// tb_aclock_display
//   Two display instances share one digit bus: dut0 (SCAN_DIV=4, BLINK_FRAMES=2,
//   LZ_BLANK=1) and dut1 (SCAN_DIV=1, BLINK_FRAMES=1, LZ_BLANK=0). A frame-level
//   reference model pushes six expected slot records per frame into exp_q0/exp_q1;
//   a monitor pops one record per slot and compares every clock.
module tb_aclock_display;
  localparam int SD0 = 4;
  localparam int BF0 = 2;
  localparam bit LZ0 = 1'b1;
  localparam int SD1 = 1;
  localparam int BF1 = 1;
  localparam bit LZ1 = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] h1 = '0;
  logic [3:0] h0 = '0, m1 = '0, m0 = '0, s1 = '0, s0 = '0;
  logic       alarm = 1'b0;

  aclock_display_if bus0();
  aclock_display_if bus1();

  assign bus0.H_out1 = h1;  assign bus1.H_out1 = h1;
  assign bus0.H_out0 = h0;  assign bus1.H_out0 = h0;
  assign bus0.M_out1 = m1;  assign bus1.M_out1 = m1;
  assign bus0.M_out0 = m0;  assign bus1.M_out0 = m0;
  assign bus0.S_out1 = s1;  assign bus1.S_out1 = s1;
  assign bus0.S_out0 = s0;  assign bus1.S_out0 = s0;
  assign bus0.Alarm  = alarm;
  assign bus1.Alarm  = alarm;

  aclock_display #(.SCAN_DIV(SD0), .BLINK_FRAMES(BF0), .LZ_BLANK(LZ0)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0));
  aclock_display #(.SCAN_DIV(SD1), .BLINK_FRAMES(BF1), .LZ_BLANK(LZ1)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1));

  logic [6:0] seg_s [2];
  logic       dp_s  [2];
  logic [5:0] an_s  [2];
  logic       fs_s  [2];
  assign seg_s[0] = bus0.seg;  assign seg_s[1] = bus1.seg;
  assign dp_s[0]  = bus0.dp;   assign dp_s[1]  = bus1.dp;
  assign an_s[0]  = bus0.an;   assign an_s[1]  = bus1.an;
  assign fs_s[0]  = bus0.frame_start;
  assign fs_s[1]  = bus1.frame_start;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [13:0] exp_q0[$];   // {an, dp, seg} per slot
  logic [13:0] exp_q1[$];
  int unsigned t = 0;       // clock edges since reset release
  int          run_len [2] = '{0, 0};
  bit          prev_alarm [2] = '{1'b0, 1'b0};
  bit          cur_on [2] = '{1'b1, 1'b1};

  // Frame rules: a frame's alarm sample starts or extends a run of alarm
  // frames; within a run, phase = (frames into run / BLINK_FRAMES) parity.
  task automatic model_frame(input int k, input logic [23:0] dg, input bit alm);
    int bf;
    bit lz;
    bit on;
    logic [13:0] rec;
    bf = (k == 0) ? BF0 : BF1;
    lz = (k == 0) ? LZ0 : LZ1;
    if (alm) run_len[k] = prev_alarm[k] ? run_len[k] + 1 : 0;
    else     run_len[k] = 0;
    prev_alarm[k] = alm;
    on = !alm || (((run_len[k] / bf) % 2) == 0);
    cur_on[k] = on;
    for (int s = 0; s < 6; s++) begin
      logic [3:0] d;
      bit blank;
      d = dg[4*s +: 4];
      blank = !on || (lz && (s == 5) && (d == 4'd0));
      rec = blank ? 14'd0 : {6'(1 << s), ((s == 2) || (s == 4)), seg_tab[d]};
      if (k == 0) exp_q0.push_back(rec);
      else        exp_q1.push_back(rec);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      t = 0;
      exp_q0.delete();
      exp_q1.delete();
      run_len    = '{0, 0};
      prev_alarm = '{1'b0, 1'b0};
      cur_on     = '{1'b1, 1'b1};
    end else begin
      t = t + 1;
      if (t == 1) begin
        model_frame(0, 24'd0, 1'b0);
        model_frame(1, 24'd0, 1'b0);
      end
      if (t % (6 * SD0) == 0) model_frame(0, {2'b00, h1, h0, m1, m0, s1, s0}, alarm);
      if (t % (6 * SD1) == 0) model_frame(1, {2'b00, h1, h0, m1, m0, s1, s0}, alarm);
    end
  end

  // ---------------- scoreboard monitor ----------------
  int checks = 0;
  int errors = 0;
  bit rst_prev = 1'b1;
  logic [13:0] cur_rec [2] = '{14'd0, 14'd0};

  task automatic check_zero(input int k, input string name);
    checks++;
    if (an_s[k] !== 6'd0 || seg_s[k] !== 7'd0 || dp_s[k] !== 1'b0 || fs_s[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s dut%0d: got an=%b seg=%h dp=%b fs=%b, want all zero",
               name, k, an_s[k], seg_s[k], dp_s[k], fs_s[k]);
    end
  endtask

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (rst_prev && !rst_n) begin
      #1;  // no clock edge in between: clearing must be asynchronous
      check_zero(0, "async_clr");
      check_zero(1, "async_clr");
    end else if (!rst_n) begin
      check_zero(0, "reset_out");
      check_zero(1, "reset_out");
    end else if (t >= 1) begin
      for (int k = 0; k < 2; k++) begin
        int sd;
        int unsigned pos;
        logic [14:0] act, expv;
        sd  = (k == 0) ? SD0 : SD1;
        pos = (t - 1) % (6 * sd);
        if (pos % sd == 0) begin
          if (k == 0 && exp_q0.size() > 0)      cur_rec[k] = exp_q0.pop_front();
          else if (k == 1 && exp_q1.size() > 0) cur_rec[k] = exp_q1.pop_front();
          else begin
            checks++;
            errors++;
            $display("FAIL underflow dut%0d: no expected slot at t=%0d", k, t);
            cur_rec[k] = 14'd0;
          end
        end
        act  = {fs_s[k], an_s[k], dp_s[k], seg_s[k]};
        expv = {(pos == 0), cur_rec[k]};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL slot dut%0d t=%0d pos=%0d: got fs=%b an=%b dp=%b seg=%h, want fs=%b an=%b dp=%b seg=%h",
                   k, t, pos, act[14], act[13:8], act[7], act[6:0],
                   expv[14], expv[13:8], expv[7], expv[6:0]);
        end
      end
    end
    rst_prev = rst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input logic [1:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
    h1 = a; h0 = b; m1 = c; m0 = d; s1 = e; s0 = f;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Assert reset mid-slot while dut0 shows digit 3 in the requested blink phase.
  task automatic reset_at_slot3(input bit want_on);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      #2;
      if (((t / SD0) % 6) == 3 && cur_on[0] == want_on) found = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    release_reset();

    wait_clks(10);
    set_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);   // 12:34:56 mid-frame
    wait_clks(40);
    set_time(2'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0);   // 09:00:00, leading zero
    wait_clks(60);
    set_time(2'd1, 4'd2, 4'd3, 4'd12, 4'd5, 4'd6);  // invalid minute units
    wait_clks(60);
    set_time(2'd3, 4'd15, 4'd5, 4'd9, 4'd0, 4'd7);  // out-of-range hour tens
    wait_clks(30);

    for (int i = 0; i < 40; i++) begin
      set_time(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      alarm = ($urandom_range(0, 3) == 0);
      wait_clks($urandom_range(1, 30));
    end

    alarm = 1'b0;
    set_time(2'd2, 4'd3, 4'd5, 4'd9, 4'd4, 4'd8);
    wait_clks(30);
    alarm = 1'b1;                                  // 8+ frames of dut0 blinking
    wait_clks(8 * 6 * SD0 + 10);
    alarm = 1'b0;
    wait_clks(60);

    set_time(2'd1, 4'd7, 4'd4, 4'd1, 4'd2, 4'd8);
    wait_clks(30);
    reset_at_slot3(1'b1);                          // visible digit being cleared
    wait_clks(60);

    alarm = 1'b1;
    reset_at_slot3(1'b0);                          // dark phase being cleared
    wait_clks(40);
    alarm = 1'b0;
    wait_clks(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aclock_display.md
Name: aclock_display

Overview:
- Display back-end for the alarm clock core. Consumes the six BCD time digits and the Alarm flag, and drives a time-multiplexed, 6-digit, common-cathode 7-segment display.
- Samples the digits once per scan frame, so a frame never shows a mix of old and new digits.
- Blanks the whole display at a slow rate while Alarm is high, so the display flashes during an alarm.
- Sits directly downstream of the clock core on the same system clock.

Parameters:
- SCAN_DIV, 4, clk cycles each digit stays selected; legal range 1..255.
- BLINK_FRAMES, 8, scan frames per blink half-period while the alarm is active; legal range 1..255.
- LZ_BLANK, 1, when 1 the hour-tens digit is blanked if it is 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- H_out1  in  2  hour tens digit (BCD 0..2).
- H_out0  in  4  hour units digit.
- M_out1  in  4  minute tens digit.
- M_out0  in  4  minute units digit.
- S_out1  in  4  second tens digit.
- S_out0  in  4  second units digit.
- Alarm  in  1  alarm active, level.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  out  1  decimal point, active-high; used as the colon separator.
- an  out  6  digit enable, one-hot, active-high; bit 0 = S_out0 (rightmost), bit 5 = H_out1.
- frame_start  out  1  one-clk pulse when digit 0 is entered.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: seg=0, dp=0, an=0, frame_start=0.
  - Internal: scan_cnt=0, dig_idx=0, all snapshot digits=0, snap_alarm=0, frame_cnt=0, blink_on=1.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - At scan_cnt==SCAN_DIV-1, dig_idx advances 0→1→…→5→0.
  - One frame is 6*SCAN_DIV clks.
- Snapshot:
  - On the clk where dig_idx wraps 5→0, all six inputs and Alarm are latched into snapshot registers.
  - The first frame after reset shows the reset snapshot (all zero).
  - Input changes mid-frame have no effect until the next wrap.
- Output register:
  - seg, dp and an are registered from the (dig_idx, snapshot) values that hold after each clk edge. They therefore lag dig_idx by 1 clk.
  - frame_start is registered the same way: it is 1 for exactly the clk where the registered an becomes 6'b000001.
- Decode, digit value → seg:
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66.
  - 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F.
  - Any value 10..15 → 7'h40 (dash, error indication).
  - H_out1 is zero-extended to 4 bits before decode.
- dp is 1 when dig_idx is 2 (M_out0) or 4 (H_out0), subject to the same blanking as an.
- Leading zero: when LZ_BLANK=1, dig_idx=5 and the snapshot H_out1=0, then an=0, seg=0, dp=0 for that slot. Scan timing is unchanged.
- Blink, driven by snap_alarm:
  - snap_alarm=0: frame_cnt is held at 0 and blink_on=1.
  - snap_alarm=1: frame_cnt increments at each frame wrap. When it reaches BLINK_FRAMES-1, it wraps to 0 and blink_on toggles.
  - The first frame with snap_alarm=1 is always an on-phase.
  - blink_on=0 forces an=0, seg=0, dp=0; scanning continues.
  - When snap_alarm falls, the display returns to on at the next frame; it cannot stay dark.
- Widths: frame_cnt is 8 bits, scan_cnt is 8 bits, dig_idx is 3 bits. dig_idx values 6..7 are unreachable; if ever present, they force dig_idx=0 on the next clk.
- Reset mid-frame: all state returns to reset values immediately. After release, scanning restarts at digit 0 with scan_cnt=0.

Test Plan:
- Reset and first cycles:
  - Stimulus: hold reset=0 for 5 clks, then release; SCAN_DIV=4.
  - Required: an=0 and seg=0 during reset. The first post-release an=6'b000001 with seg=7'h3F. an advances every 4 clks and reaches 6'b100000 at the 21st clk after release.
- Snapshot of 12:34:56:
  - Stimulus: inputs 1,2,3,4,5,6 applied mid-frame.
  - Required: the old digits hold until the frame wrap. The next frame shows digit0=7'h7D, 1=7'h6D, 2=7'h66 with dp=1, 3=7'h4F, 4=7'h5B with dp=1, 5=7'h06.
- Leading zero:
  - Stimulus: 09:00:00 with LZ_BLANK=1.
  - Required: slot 5 has an=0 and seg=0. Slot 4 shows 7'h6F with dp=1.
  - Rerun with LZ_BLANK=0: slot 5 shows 7'h3F.
- Invalid digit:
  - Stimulus: M_out0=4'd12.
  - Required: slot 2 shows seg=7'h40 with dp=1.
- Alarm blink:
  - Stimulus: BLINK_FRAMES=2; raise Alarm for 8 frames.
  - Required: the pattern is 2 frames on, 2 off, 2 on, 2 off. During off frames an=0 while frame_start still pulses. Dropping Alarm restores the display within 1 frame.
- Reset mid-operation:
  - Stimulus: assert reset while dig_idx=3 and blink_on=0.
  - Required: outputs clear within the same clk without any clock edge. After release: an=6'b000001, blink_on=1, snapshot all zero.
